// File: rtl/instr_encoder_writer_pkg.sv
// Shared opcodes, instruction-class and FSM enums, plus field packing helpers
// for the instruction encoder/writer.
package instr_enc_pkg;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    typedef enum logic [1:0] {
        KIND_R   = 2'd0,
        KIND_LD  = 2'd1,
        KIND_ST  = 2'd2,
        KIND_BEQ = 2'd3
    } kind_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic [31:0] encode(
        input logic [1:0]  kind,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [2:0]  funct3,
        input logic [6:0]  funct7,
        input logic [12:0] imm
    );
        logic [31:0] w;
        case (kind)
            KIND_R:  w = {funct7, rs2, rs1, funct3, rd, OP_R};
            KIND_LD: w = {imm[11:0], rs1, funct3, rd, OP_LD};
            KIND_ST: w = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_ST};
            default: w = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BEQ};
        endcase
        return w;
    endfunction

    // Field sets the single-cycle core cannot execute correctly.
    function automatic logic fields_legal(
        input logic [1:0]  kind,
        input logic [2:0]  funct3,
        input logic [6:0]  funct7,
        input logic [12:0] imm
    );
        logic ok;
        case (kind)
            KIND_R:  ok = (funct7 == 7'h00) || (funct7 == 7'h20);
            KIND_LD,
            KIND_ST: ok = (funct3 == 3'b010);
            default: ok = !imm[0] && (funct3 == 3'b000);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/instr_encoder_writer_fifo.sv
// Synchronous FIFO buffering encoded words; DEPTH must be a power of 2 (>= 2).
module instr_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == FULL_CNT);
    assign empty   = (cnt == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage is data only; validity is tracked by the pointers above.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/instr_encoder_writer.sv
// Encodes R/LW/SW/BEQ field sets into RISC-V words and streams them into
// instruction memory. Define INSTR_ENC_CHECK_EN to drop illegal field sets and flag err.
module instr_encoder_writer
    import instr_enc_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_kind,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [12:0]       imm,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              flush,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic              imem_ready,
    output logic              done,
    output logic              wrapped,
    output logic [ADDR_W:0]   count,
    output logic              err
);

    localparam logic [ADDR_W:0] COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

    state_e      state;
    state_e      state_nxt;
    logic        flush_pend;
    logic [31:0] enc_word;
    logic [31:0] head;
    logic        fifo_full;
    logic        fifo_empty;
    logic        legal;
    logic        push;
    logic        pop;
    logic        launch;

    assign enc_word = encode(in_kind, rd, rs1, rs2, funct3, funct7, imm);

`ifdef INSTR_ENC_CHECK_EN
    assign legal = fields_legal(in_kind, funct3, funct7, imm);
`else
    assign legal = 1'b1;
`endif

    // An illegal set still completes its handshake; it just never enters the FIFO.
    assign in_ready   = !fifo_full;
    assign push       = in_valid && in_ready && legal;
    assign imem_we    = (state == RUN) && !fifo_empty;
    assign imem_wdata = imem_we ? head : 32'h0;
    assign pop        = imem_we && imem_ready;
    assign done       = (state == DONE);
    assign launch     = start && (state != RUN);

    instr_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .wdata   (enc_word),
        .rdata   (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // The run ends only once the FIFO is drained and nothing new is arriving.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if ((flush || flush_pend) && fifo_empty && !push) state_nxt = DONE;
            DONE:    if (start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flush_pend <= 1'b0;
        end else if (state != RUN || state_nxt == DONE) begin
            flush_pend <= 1'b0;
        end else if (flush) begin
            flush_pend <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            imem_addr <= '0;
            count     <= '0;
            wrapped   <= 1'b0;
        end else if (launch) begin
            imem_addr <= base_addr;
            count     <= '0;
            wrapped   <= 1'b0;
        end else if (pop) begin
            imem_addr <= imem_addr + 1'b1;
            if (count != COUNT_MAX) count <= count + 1'b1;
            if (&imem_addr) wrapped <= 1'b1;
        end
    end

`ifdef INSTR_ENC_CHECK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err <= 1'b0;
        end else if (in_valid && in_ready && !legal) begin
            err <= 1'b1;
        end else if (launch) begin
            err <= 1'b0;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: doc/instr_encoder_writer.md
Name: instr_encoder_writer

Overview:
- Encoder counterpart of the opcode decoder: packs instruction fields for the four supported classes (R-type, LW, SW, BEQ) into 32-bit RISC-V words.
- Buffers encoded words in a small FIFO and streams them into instruction memory at consecutive addresses.
- Used by the test loader and by program download into the single-cycle core.

Parameters:
- ADDR_W, 8, instruction-memory word-address width.
- FIFO_DEPTH, 4, encoded-word buffer depth; power of 2, minimum 2.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  field set valid.
- in_ready  out  1  field set accepted when in_valid && in_ready.
- in_kind  in  2  instruction class: 0=R, 1=LD, 2=ST, 3=BEQ.
- rd, rs1, rs2  in  5 each  register fields.
- funct3  in  3  funct3 field.
- funct7  in  7  funct7 field; used by R only.
- imm  in  13  immediate; LD/ST use imm[11:0]; BEQ uses imm[12:1].
- start  in  1  pulse: begin a write run at base_addr.
- base_addr  in  ADDR_W  first memory address of a run.
- flush  in  1  pulse: finish the run once the FIFO drains.
- imem_we  out  1  memory write strobe.
- imem_addr  out  ADDR_W  memory write address.
- imem_wdata  out  32  encoded instruction.
- imem_ready  in  1  memory accepts the write this cycle.
- done  out  1  high in DONE.
- wrapped  out  1  sticky: address wrapped during the run.
- count  out  ADDR_W+1  words written since the last start.
- err  out  1  sticky illegal-field flag.

Behaviour:
- Reset values: FIFO empty; state IDLE; imem_we=0, imem_addr=0, imem_wdata=0, done=0, wrapped=0, count=0, err=0. in_ready=1.
- Encoding is combinational on push:
  - R: {funct7, rs2, rs1, funct3, rd, 7'b0110011}.
  - LD: {imm[11:0], rs1, funct3, rd, 7'b0000011}.
  - ST: {imm[11:5], rs2, rs1, funct3, imm[4:0], 7'b0100011}.
  - BEQ: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 7'b1100011}.
- Unused fields for a class are ignored.
- in_ready = !fifo_full. There is no bypass when full.
- Push and pop in the same cycle are allowed when non-empty; occupancy is unchanged.
- Input is accepted in every state; the FIFO may fill while IDLE or DONE.
- FSM:
  - IDLE: start -> RUN; imem_addr:=base_addr, count:=0, wrapped:=0.
  - RUN: imem_we = !empty, imem_wdata = FIFO head.
    - On imem_we && imem_ready: pop, imem_addr+1 (mod 2^ADDR_W), count+1.
    - If imem_addr was all-ones at that write, wrapped:=1.
    - imem_we stays high with stable addr/data while imem_ready=0.
  - RUN flush handling: a flush pulse sets an internal flush_pend. When flush_pend && FIFO empty && no push this cycle -> DONE, clear flush_pend. If the FIFO is already empty, DONE follows on the next cycle.
  - DONE: done=1, imem_we=0. start -> RUN with the same initialisation as from IDLE.
- start while in RUN is ignored. flush while in IDLE or DONE is ignored.
- Latency: a word accepted at cycle N can be written to memory (imem_we visible) at N+1 at the earliest.
- count saturates at 2^ADDR_W.
- Asynchronous reset mid-run returns everything to reset values; FIFO contents are discarded.

Optional Feature:
- Macro: INSTR_ENC_CHECK_EN.
- Defined:
  - A field set is illegal when: R with funct7 not in {7'h00, 7'h20}; LD/ST with funct3 != 3'b010; BEQ with imm[0]=1 or funct3 != 3'b000.
  - An illegal set is handshaked (in_ready unchanged) but not pushed. err:=1 (sticky until reset or start).
- Undefined: no checks; all fields are encoded raw; err is tied to 0.

Decomposition:
- Package instr_enc_pkg holds:
  - opcode constants OP_R=7'b0110011, OP_LD=7'b0000011, OP_ST=7'b0100011, OP_BEQ=7'b1100011;
  - the in_kind enum;
  - the FSM state enum (IDLE, RUN, DONE).
- Sub-module instr_fifo: synchronous FIFO parameterised by width and depth, with full/empty outputs. The top holds the encoder, FSM and address/count logic.

Test Plan:
- start with base_addr=0x10, push R rd=3 rs1=1 rs2=2 f3=0 f7=0 -> write 0x002081B3 at address 0x10, count=1.
- Push LD rd=5 rs1=2 f3=2 imm=8, then ST rs2=6 rs1=2 f3=2 imm=12 -> 0x00812283 at base, 0x00612623 at base+1.
- Push BEQ rs1=1 rs2=2 imm=13'h1FF8 -> 0xFE208CE3.
- In IDLE, push 5 words with FIFO_DEPTH=4 -> in_ready low after the 4th. Then start with imem_ready toggling 1,0,1,1,… -> addr/data held while stalled; all 5 words written in order.
- base_addr=0xFF, 2 words, flush -> writes at 0xFF then 0x00, wrapped=1, count=2, done=1 one cycle after the FIFO empties.
- With INSTR_ENC_CHECK_EN: BEQ imm=13'h0003 -> no write, err=1. Without the macro the same input -> word written, err=0.
